// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command controller.
// Parser states, error codes and the checksum helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    CHK
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CHK   = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  localparam logic [7:0] SYNC_DEF = 8'hA5;

  function automatic logic [7:0] chk_sum(
    input logic [7:0] a,
    input logic [7:0] d
  );
    return a + d;
  endfunction

endpackage

// File: rtl/uart_reg_bank.sv
// 16x8 configuration register bank.
// One synchronous write port, one asynchronous read port.
module uart_reg_bank (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_we,
  input  logic [3:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [3:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser behind the UART receiver: SYNC, ADDR, DATA, CHK.
// Validated frames commit to the register bank; bad ones report err_code.
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ      = 50000000,
  parameter int         UART_BPS      = 9600,
  parameter int         TIMEOUT_BYTES = 3,
  parameter logic [7:0] SYNC_BYTE     = SYNC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       reg_wr_en,
  output logic [3:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int LIMIT = TIMEOUT_BYTES * 10 * (CLK_FREQ / UART_BPS);
  localparam int CW    = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM_M1 = CW'(LIMIT - 1);

  state_t      r_state;
  logic [7:0]  r_addr;
  logic [7:0]  r_data;
  logic [CW-1:0] r_cnt;
  logic        r_wr_en;
  logic [3:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_ok;
  logic        r_err;
  logic [1:0]  r_code;

  logic w_chk_byte;
  logic w_bad_chk;
  logic w_bad_rng;
  logic w_commit;

  assign w_chk_byte = rx_valid && (r_state == CHK);
  assign w_bad_chk  = chk_sum(r_addr, r_data) != rx_data;
  assign w_bad_rng  = !w_bad_chk && (r_addr[7:4] != 4'h0);
  assign w_commit   = w_chk_byte && !w_bad_chk && !w_bad_rng;

  uart_reg_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_commit),
    .i_waddr (r_addr[3:0]),
    .i_wdata (r_data),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
      r_code    <= ERR_NONE;
    end else begin
      r_wr_en <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      // An arriving byte always beats an expiring timer.
      if (rx_valid || r_state == IDLE) begin
        r_cnt <= '0;
      end else if (r_cnt == LIM_M1) begin
        r_cnt   <= '0;
        r_state <= IDLE;
        r_err   <= 1'b1;
        r_code  <= ERR_TMO;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (rx_valid) begin
        unique case (r_state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) r_state <= ADDR;
          end
          ADDR: begin
            r_addr  <= rx_data;
            r_state <= DATA;
          end
          DATA: begin
            r_data  <= rx_data;
            r_state <= CHK;
          end
          CHK: begin
            r_state <= IDLE;
            unique case (1'b1)
              w_bad_chk: begin
                r_err  <= 1'b1;
                r_code <= ERR_CHK;
              end
              w_bad_rng: begin
                r_err  <= 1'b1;
                r_code <= ERR_RANGE;
              end
              default: begin
                r_wr_en   <= 1'b1;
                r_ok      <= 1'b1;
                r_code    <= ERR_NONE;
                r_wr_addr <= r_addr[3:0];
                r_wr_data <= r_data;
              end
            endcase
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign reg_wr_en   = r_wr_en;
  assign reg_wr_addr = r_wr_addr;
  assign reg_wr_data = r_wr_data;
  assign frame_ok    = r_ok;
  assign frame_err   = r_err;
  assign err_code    = r_code;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: directed frames, timeout,
// mid-frame reset and randomized frames against a frame-level model.
module tb_uart_cmd_ctrl;

  localparam int TMO = 3 * 10 * (50000000 / 9600);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       reg_wr_en;
  logic [3:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  typedef struct {
    bit         ok;
    logic [1:0] code;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model [16];
  int         n_chk  = 0;
  int         n_pass = 0;

  uart_cmd_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t",
                  nm, act, exp, $time);
  endtask

  // Monitor: samples 2ns after each rising edge.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("wr_en_eq_ok", reg_wr_en, frame_ok);
      if (frame_ok || frame_err) begin
        chk("ok_err_excl", frame_ok & frame_err, 0);
        chk("pending_expect", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("frame_ok", frame_ok, e.ok);
          chk("frame_err", frame_err, !e.ok);
          chk("err_code", err_code, e.code);
          if (e.ok) begin
            model[e.addr] = e.data;
            chk("wr_addr", reg_wr_addr, e.addr);
            chk("wr_data", reg_wr_data, e.data);
          end
          chk("rd_data", rd_data, model[rd_addr]);
        end
      end
    end
  end

  // Caller sits at a negedge; gap 0 gives back-to-back strobes.
  task automatic put(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] c, input int gap);
    exp_t e;
    logic [7:0] s;
    s = 8'((int'(a) + int'(d)) % 256);
    e.addr = a[3:0];
    e.data = d;
    if (c != s) begin
      e.ok = 0; e.code = 2'b01;
    end else if (a > 8'd15) begin
      e.ok = 0; e.code = 2'b10;
    end else begin
      e.ok = 1; e.code = 2'b00;
    end
    exp_q.push_back(e);
    put(8'hA5, gap);
    put(a, gap);
    put(d, gap);
    put(c, gap);
  endtask

  task automatic sweep(input string nm);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk(nm, rd_data, model[i]);
    end
  endtask

  initial begin
    exp_t e;
    logic [7:0] a, d, c, g;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rd_addr  = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", reg_wr_en, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_wr_addr", reg_wr_addr, 0);
    chk("rst_wr_data", reg_wr_data, 0);
    sweep("rst_bank");
    rst_n = 1'b1;
    @(negedge clk);

    rd_addr = 4'd3;
    frame(8'h03, 8'h5C, 8'h5F, 1);
    frame(8'h03, 8'h5C, 8'h60, 1);
    frame(8'h13, 8'h5C, 8'h6F, 0);
    frame(8'h13, 8'h5C, 8'h00, 0);
    chk("bank3_kept", rd_data, 8'h5C);

    rd_addr = 4'd15;
    put(8'h00, 0);
    put(8'hFF, 1);
    frame(8'h0F, 8'h80, 8'h8F, 0);
    chk("bank15", rd_data, 8'h80);

    // Silence after ADDR byte: timeout exactly TMO cycles later.
    e.ok = 0; e.code = 2'b11; e.addr = 0; e.data = 0;
    exp_q.push_back(e);
    put(8'hA5, 0);
    put(8'h02, 0);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_busy_pre", busy, 1);
    chk("tmo_err_pre", frame_err, 0);
    @(negedge clk);
    chk("tmo_err", frame_err, 1);
    chk("tmo_code", err_code, 2'b11);
    @(negedge clk);
    chk("tmo_busy_post", busy, 0);

    // Byte on the expiry cycle keeps the frame alive.
    rd_addr = 4'd2;
    e.ok = 1; e.code = 2'b00; e.addr = 4'd2; e.data = 8'h5C;
    exp_q.push_back(e);
    put(8'hA5, 0);
    put(8'h02, 0);
    repeat (TMO - 1) @(negedge clk);
    put(8'h5C, 0);
    chk("expiry_busy", busy, 1);
    put(8'h5E, 0);
    chk("expiry_commit", rd_data, 8'h5C);

    // Reset mid-frame.
    put(8'hA5, 0);
    put(8'h07, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    chk("midrst_busy", busy, 0);
    sweep("midrst_bank");
    @(negedge clk);
    rd_addr = 4'd7;
    frame(8'h07, 8'h11, 8'h18, 0);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        put(g, int'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(0, 15));
      else a = 8'($urandom_range(16, 255));
      d = 8'($urandom);
      c = 8'((int'(a) + int'(d)) % 256);
      if ($urandom_range(0, 4) == 0) c = c + 8'($urandom_range(1, 255));
      rd_addr = 4'($urandom);
      frame(a, d, c, int'($urandom_range(0, 2)));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    sweep("final_bank");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
